// File: rtl/hawk_pg_wr_pkg.sv
// Shared types, AXI constants and page geometry helpers for the Hawk page-write engine.
package hawk_pg_wr_pkg;

  typedef enum logic [2:0] {StIdle, StAw, StW, StDrain, StDone} pg_wr_state_e;

  typedef enum logic {FillZero = 1'b0, FillPattern = 1'b1} pg_fill_mode_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int unsigned page_beats(input int unsigned page_bytes,
                                             input int unsigned data_w);
    return page_bytes / (data_w / 8);
  endfunction

  function automatic int unsigned page_bursts(input int unsigned page_bytes,
                                              input int unsigned data_w,
                                              input int unsigned burst_beats);
    return page_beats(page_bytes, data_w) / burst_beats;
  endfunction

endpackage

// File: rtl/hawk_rr_arb.sv
// N-way round-robin arbiter; search starts one past the last accepted grant.
module hawk_rr_arb
  import hawk_pg_wr_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = $clog2(N) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  input  logic            accept_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    int idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx       = 0;
    if (en_i) begin
      // Walk offsets downward so the smallest offset from the pointer wins last.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        idx = int'(ptr_q) + i;
        if (idx >= int'(N)) idx = idx - int'(N);
        if (req_i[idx]) begin
          gnt_o      = '0;
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = IdxW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (accept_i) begin
      ptr_q <= (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/hawk_pg_wr_engine.sv
// Multi-channel page-fill engine: writes one zero or pattern page per request as AXI4
// INCR bursts, then reports completion with a sticky error flag.
module hawk_pg_wr_engine
  import hawk_pg_wr_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned ID_VAL      = 0,
  parameter int unsigned PAGE_BYTES  = 4096,
  parameter int unsigned BURST_BEATS = 16,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned MAX_OUTST   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CH-1:0]         req_valid_i,
  output logic [NUM_CH-1:0]         req_ready_o,
  input  logic [NUM_CH*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_CH-1:0]         req_mode_i,
  input  logic [NUM_CH*64-1:0]      req_pat_i,
  output logic                      done_o,
  output logic [$clog2(NUM_CH):0]   done_ch_o,
  output logic                      done_err_o,
  output logic                      busy_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [ADDR_W-1:0]         m_awaddr_o,
  output logic [7:0]                m_awlen_o,
  output logic [2:0]                m_awsize_o,
  output logic [1:0]                m_awburst_o,
  output logic [ID_W-1:0]           m_awid_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  output logic [DATA_W-1:0]         m_wdata_o,
  output logic [DATA_W/8-1:0]       m_wstrb_o,
  output logic                      m_wlast_o,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  input  logic [1:0]                m_bresp_i
);

  localparam int unsigned NBurst     = page_bursts(PAGE_BYTES, DATA_W, BURST_BEATS);
  localparam int unsigned BurstBytes = BURST_BEATS * (DATA_W / 8);
  localparam int unsigned IdxW       = $clog2(NUM_CH) + 1;
  localparam int unsigned BurstW     = $clog2(NBurst) + 1;
  localparam int unsigned BeatW      = $clog2(BURST_BEATS) + 1;
  localparam int unsigned OutW       = $clog2(MAX_OUTST) + 1;
  localparam logic [ADDR_W-1:0] PageMask = ~ADDR_W'(PAGE_BYTES - 1);

  pg_wr_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  pg_fill_mode_e     mode_q;
  logic [63:0]       pat_q;
  logic [IdxW-1:0]   ch_q;
  logic [BurstW-1:0] burst_q;
  logic [BeatW-1:0]  beat_q;
  logic [OutW-1:0]   outst_q;
  logic              err_q;

  logic [NUM_CH-1:0] gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              arb_en, accept, aw_hs, w_hs, b_hs, last_beat, last_burst;
  logic [ADDR_W-1:0] sel_addr;
  pg_fill_mode_e     sel_mode;
  logic [63:0]       sel_pat;

  hawk_rr_arb #(
    .N    (NUM_CH),
    .IdxW (IdxW)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (arb_en),
    .req_i     (req_valid_i),
    .accept_i  (accept),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign accept      = |(req_valid_i & gnt);
  assign aw_hs       = m_awvalid_o & m_awready_i;
  assign w_hs        = m_wvalid_o & m_wready_i;
  assign b_hs        = m_bvalid_i & m_bready_o;
  assign last_beat   = (beat_q == BeatW'(BURST_BEATS - 1));
  assign last_burst  = (burst_q == BurstW'(NBurst - 1));

  always_comb begin
    sel_addr = '0;
    sel_mode = FillZero;
    sel_pat  = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (gnt[c]) begin
        sel_addr = req_addr_i[c*ADDR_W +: ADDR_W];
        sel_mode = pg_fill_mode_e'(req_mode_i[c]);
        sel_pat  = req_pat_i[c*64 +: 64];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAw;
      StAw:    if (aw_hs) state_d = StW;
      StW:     if (w_hs && last_beat) state_d = last_burst ? StDrain : StAw;
      StDrain: if (outst_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    arb_en      = 1'b0;
    busy_o      = 1'b1;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b1;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        arb_en     = 1'b1;
        busy_o     = 1'b0;
        m_bready_o = 1'b0;
      end
      // Outstanding can only fall while waiting here, so awvalid never retracts.
      StAw:    m_awvalid_o = (outst_q < OutW'(MAX_OUTST));
      StW:     m_wvalid_o  = 1'b1;
      StDone:  done_o      = 1'b1;
      default: ;
    endcase
  end

  assign m_wlast_o   = m_wvalid_o & last_beat;
  assign done_ch_o   = done_o ? ch_q : '0;
  assign done_err_o  = done_o & err_q;
  assign m_awaddr_o  = addr_q + ADDR_W'(burst_q) * ADDR_W'(BurstBytes);
  assign m_awlen_o   = 8'(BURST_BEATS - 1);
  assign m_awsize_o  = 3'($clog2(DATA_W / 8));
  assign m_awburst_o = AXI_BURST_INCR;
  assign m_awid_o    = ID_W'(ID_VAL);
  assign m_wdata_o   = (mode_q == FillPattern) ? {(DATA_W/64){pat_q}} : '0;
  assign m_wstrb_o   = '1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      mode_q  <= FillZero;
      pat_q   <= '0;
      ch_q    <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= sel_addr & PageMask;
        mode_q  <= sel_mode;
        pat_q   <= sel_pat;
        ch_q    <= gnt_idx;
        burst_q <= '0;
        beat_q  <= '0;
      end
      if (w_hs) begin
        if (last_beat) begin
          beat_q  <= '0;
          burst_q <= burst_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
      if (aw_hs && !b_hs)      outst_q <= outst_q + 1'b1;
      else if (!aw_hs && b_hs) outst_q <= outst_q - 1'b1;
      if (state_q == StDone)                         err_q <= 1'b0;
      else if (b_hs && m_bresp_i != AXI_RESP_OKAY)   err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hawk_pg_wr_engine.sv
// Randomized bench for hawk_pg_wr_engine: reactive AXI slave, per-request page model
// and a negedge compare process, plus literal expectations for directed scenarios.
module tb_hawk_pg_wr_engine;

  localparam int ADDR_W      = 64;
  localparam int DATA_W      = 512;
  localparam int ID_W        = 4;
  localparam int PAGE_BYTES  = 4096;
  localparam int BURST_BEATS = 16;
  localparam int NUM_CH      = 2;
  localparam int MAX_OUTST   = 4;
  localparam int NBURST      = PAGE_BYTES / (DATA_W / 8) / BURST_BEATS;
  localparam int BURST_BYTES = BURST_BEATS * DATA_W / 8;
  localparam int HOLD_LVL    = (MAX_OUTST < NBURST) ? MAX_OUTST : NBURST;
  localparam int CW          = $clog2(NUM_CH) + 1;

  typedef struct {
    logic [63:0] addr;
    logic        mode;
    logic [63:0] pat;
    int          err_burst;
  } req_t;

  typedef struct {
    int   ch;
    logic err;
  } done_t;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH-1:0]        req_mode = '0;
  logic [NUM_CH*64-1:0]     req_pat = '0;
  logic                     done, done_err, busy;
  logic [CW-1:0]            done_ch;
  logic                     m_awvalid, m_awready = 1'b0;
  logic [ADDR_W-1:0]        m_awaddr;
  logic [7:0]               m_awlen;
  logic [2:0]               m_awsize;
  logic [1:0]               m_awburst;
  logic [ID_W-1:0]          m_awid;
  logic                     m_wvalid, m_wready = 1'b0, m_wlast;
  logic [DATA_W-1:0]        m_wdata;
  logic [DATA_W/8-1:0]      m_wstrb;
  logic                     m_bvalid = 1'b0, m_bready;
  logic [1:0]               m_bresp = 2'b00;

  always #5 clk = ~clk;

  hawk_pg_wr_engine #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .ID_W        (ID_W),
    .ID_VAL      (0),
    .PAGE_BYTES  (PAGE_BYTES),
    .BURST_BEATS (BURST_BEATS),
    .NUM_CH      (NUM_CH),
    .MAX_OUTST   (MAX_OUTST)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_mode_i  (req_mode),
    .req_pat_i   (req_pat),
    .done_o      (done),
    .done_ch_o   (done_ch),
    .done_err_o  (done_err),
    .busy_o      (busy),
    .m_awvalid_o (m_awvalid),
    .m_awready_i (m_awready),
    .m_awaddr_o  (m_awaddr),
    .m_awlen_o   (m_awlen),
    .m_awsize_o  (m_awsize),
    .m_awburst_o (m_awburst),
    .m_awid_o    (m_awid),
    .m_wvalid_o  (m_wvalid),
    .m_wready_i  (m_wready),
    .m_wdata_o   (m_wdata),
    .m_wstrb_o   (m_wstrb),
    .m_wlast_o   (m_wlast),
    .m_bvalid_i  (m_bvalid),
    .m_bready_o  (m_bready),
    .m_bresp_i   (m_bresp)
  );

  int n_cmp = 0, n_bad = 0;

  // Stimulus queues and slave knobs
  req_t rq0[$], rq1[$];
  req_t pres[NUM_CH];
  int   aw_p = 100, w_p = 100, b_p = 100;
  bit   b_hold = 1'b0;

  // Model state (owned by the compare process)
  bit          m_idle = 1'b1;
  int          ptr = 0, cur_ch = 0, cur_err_burst = -1;
  logic [63:0] cur_base = '0, cur_pat = '0;
  logic        cur_mode = 1'b0, cur_err = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, pending_b = 0, max_outst = 0;
  bit          hold_rel = 1'b0;
  int          acc_cnt[NUM_CH];
  int          b_total = 0, done_cnt = 0;
  bit          aw_stall_prev = 1'b0, w_stall_prev = 1'b0;
  logic [63:0] aw_addr_prev = '0;
  logic [DATA_W-1:0] w_data_prev = '0;
  done_t       done_log[$];
  int          grant_log[$];
  logic [63:0] aw_log[$];
  logic [DATA_W-1:0] wfirst_log[$];

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_idle = 1'b1; ptr = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; pending_b = 0;
    hold_rel = 1'b0; cur_err = 1'b0; aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
  endtask

  // Compare process: every handshake is judged at the negedge before the edge that takes it.
  always @(negedge clk) begin : mon
    logic [NUM_CH-1:0] exp_rdy;
    logic [DATA_W-1:0] exp_w;
    int g;
    if (rst_i) begin
      model_clear();
    end else begin
      exp_rdy = '0;
      g = -1;
      if (m_idle)
        for (int i = NUM_CH - 1; i >= 0; i--)
          if (req_valid[(ptr + i) % NUM_CH]) g = (ptr + i) % NUM_CH;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, !m_idle);
      chk("bready", m_bready, !m_idle);

      if (w_stall_prev) begin
        chk("w_hold_valid", m_wvalid, 1);
        chk("w_hold_data", m_wdata, w_data_prev);
      end
      if (m_wvalid) begin
        chk("w_after_aw", w_cnt < aw_cnt * BURST_BEATS, 1);
        if (m_wready) begin
          exp_w = '0;
          if (cur_mode) for (int k = 0; k < DATA_W / 64; k++) exp_w[k*64 +: 64] = cur_pat;
          chk("wdata", m_wdata, exp_w);
          chk("wlast", m_wlast, (w_cnt % BURST_BEATS) == BURST_BEATS - 1);
          chk("wstrb", m_wstrb, {(DATA_W/8){1'b1}});
          if (w_cnt == 0) wfirst_log.push_back(m_wdata);
          if ((w_cnt % BURST_BEATS) == BURST_BEATS - 1) begin
            pending_b++;
            if (pending_b >= HOLD_LVL) hold_rel = 1'b1;
          end
          w_cnt++;
        end
      end
      w_stall_prev = m_wvalid && !m_wready;
      w_data_prev  = m_wdata;

      if (aw_stall_prev) begin
        chk("aw_hold_valid", m_awvalid, 1);
        chk("aw_hold_addr", m_awaddr, aw_addr_prev);
      end
      if (m_awvalid) begin
        chk("aw_in_request", !m_idle && aw_cnt < NBURST, 1);
        chk("aw_outst_limit", (aw_cnt - b_cnt) < MAX_OUTST, 1);
        if (m_awready) begin
          chk("awaddr", m_awaddr, cur_base + 64'(aw_cnt) * 64'(BURST_BYTES));
          chk("awlen", m_awlen, BURST_BEATS - 1);
          chk("awsize", m_awsize, 6);
          chk("awburst", m_awburst, 1);
          chk("awid", m_awid, 0);
          aw_log.push_back(m_awaddr);
          aw_cnt++;
        end
      end
      aw_stall_prev = m_awvalid && !m_awready;
      aw_addr_prev  = m_awaddr;

      if (m_bvalid && m_bready) begin
        if (m_bresp != 2'b00) cur_err = 1'b1;
        b_cnt++;
        pending_b--;
        b_total++;
      end
      if (aw_cnt - b_cnt > max_outst) max_outst = aw_cnt - b_cnt;

      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          grant_log.push_back(c);
          ptr = (c + 1) % NUM_CH;
          cur_ch = c;
          cur_base = pres[c].addr & ~64'(PAGE_BYTES - 1);
          cur_mode = pres[c].mode;
          cur_pat = pres[c].pat;
          cur_err_burst = pres[c].err_burst;
          cur_err = 1'b0;
          aw_cnt = 0; w_cnt = 0; b_cnt = 0; pending_b = 0; hold_rel = 1'b0;
          acc_cnt[c]++;
          m_idle = 1'b0;
        end
      end

      if (done) begin
        chk("done_in_request", !m_idle, 1);
        chk("done_after_all_b", b_cnt, NBURST);
        chk("done_w_beats", w_cnt, NBURST * BURST_BEATS);
        chk("done_ch", done_ch, cur_ch);
        chk("done_err", done_err, cur_err);
        done_log.push_back('{cur_ch, done_err});
        done_cnt++;
        m_idle = 1'b1;
      end else begin
        chk("done_side_quiet", {done_ch, done_err}, 0);
      end
    end
  end

  task automatic present(input int c);
    req_addr[c*ADDR_W +: ADDR_W] = pres[c].addr;
    req_mode[c]                  = pres[c].mode;
    req_pat[c*64 +: 64]          = pres[c].pat;
    req_valid[c]                 = 1'b1;
  endtask

  // Requesters and AXI slave, driven 2 time units after each rising edge.
  initial begin : drv
    int acc_seen[NUM_CH];
    int b_seen;
    b_seen = 0;
    for (int c = 0; c < NUM_CH; c++) acc_seen[c] = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_i) begin
        req_valid = '0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        b_seen = b_total;
        for (int c = 0; c < NUM_CH; c++) acc_seen[c] = acc_cnt[c];
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (acc_seen[c] != acc_cnt[c]) begin
            req_valid[c] = 1'b0;
            acc_seen[c]  = acc_cnt[c];
          end else if (!req_valid[c]) begin
            if (c == 0 && rq0.size() > 0) begin pres[0] = rq0.pop_front(); present(0); end
            if (c == 1 && rq1.size() > 0) begin pres[1] = rq1.pop_front(); present(1); end
          end
        end
        m_awready = ($urandom_range(99) < aw_p);
        m_wready  = ($urandom_range(99) < w_p);
        if (m_bvalid && b_seen != b_total) m_bvalid = 1'b0;
        b_seen = b_total;
        if (!m_bvalid && pending_b > 0 && (!b_hold || hold_rel) &&
            ($urandom_range(99) < b_p)) begin
          m_bvalid = 1'b1;
          m_bresp  = (b_cnt == cur_err_burst) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  function automatic req_t rand_req(input int err_burst);
    req_t r;
    r.addr = {$urandom(), $urandom()};
    r.mode = 1'($urandom_range(1));
    r.pat  = {$urandom(), $urandom()};
    r.err_burst = err_burst;
    return r;
  endfunction

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++;
      $display("FAIL wait_done: got %0d completions expected %0d", done_cnt, target);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_awvalid"}, m_awvalid, 0);
    chk({tag, "_wvalid"}, m_wvalid, 0);
    chk({tag, "_wlast"}, m_wlast, 0);
    chk({tag, "_bready"}, m_bready, 0);
    chk({tag, "_done_ch"}, done_ch, 0);
    chk({tag, "_done_err"}, done_err, 0);
  endtask

  initial begin : main
    logic [63:0] exp_aw[4];
    int ab, db, wb, gb, n;
    logic [DATA_W-1:0] pat_line;
    exp_aw[0] = 64'h1000_0000; exp_aw[1] = 64'h1000_0400;
    exp_aw[2] = 64'h1000_0800; exp_aw[3] = 64'h1000_0C00;

    repeat (4) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_quiet("reset");

    // Zero fill on ch0, always-ready slave
    ab = aw_log.size(); db = done_log.size(); wb = wfirst_log.size();
    rq0.push_back('{64'h1000_0000, 1'b0, 64'h0123_4567_89AB_CDEF, -1});
    wait_done(1, 1000);
    chk("t1_aw_count", aw_log.size() - ab, 4);
    for (int k = 0; k < 4; k++) if (aw_log.size() > ab + k) chk("t1_awaddr_lit", aw_log[ab + k], exp_aw[k]);
    if (wfirst_log.size() > wb) chk("t1_wdata_zero", wfirst_log[wb], 0);
    if (done_log.size() > db) begin
      chk("t1_done_ch", done_log[db].ch, 0);
      chk("t1_done_err", done_log[db].err, 0);
    end

    // Pattern fill on ch1 with unaligned base
    ab = aw_log.size(); db = done_log.size(); wb = wfirst_log.size();
    rq1.push_back('{64'h2345, 1'b1, 64'hDEADBEEF_CAFEF00D, -1});
    wait_done(2, 1000);
    pat_line = {8{64'hDEADBEEF_CAFEF00D}};
    if (aw_log.size() > ab) chk("t2_awaddr_lit", aw_log[ab], 64'h2000);
    if (wfirst_log.size() > wb) chk("t2_wdata_lit", wfirst_log[wb], pat_line);
    if (done_log.size() > db) chk("t2_done_ch", done_log[db].ch, 1);

    // Both channels contending, ch0 re-requesting
    gb = grant_log.size();
    rq0.push_back(rand_req(-1)); rq0.push_back(rand_req(-1)); rq1.push_back(rand_req(-1));
    wait_done(5, 3000);
    if (grant_log.size() >= gb + 3) begin
      chk("arb_grant0", grant_log[gb], 0);
      chk("arb_grant1", grant_log[gb + 1], 1);
      chk("arb_grant2", grant_log[gb + 2], 0);
    end

    // Random backpressure with B held until the outstanding limit is reached
    aw_p = 60; w_p = 50; b_p = 40; b_hold = 1'b1; max_outst = 0;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(1) == 0) rq0.push_back(rand_req(-1));
      else rq1.push_back(rand_req(-1));
    end
    wait_done(11, 20000);
    chk("bp_max_outst", max_outst, MAX_OUTST);

    // SLVERR on burst 2, then a clean request
    b_hold = 1'b0; aw_p = 70; w_p = 70; b_p = 60;
    db = done_log.size();
    rq0.push_back(rand_req(2)); rq0.push_back(rand_req(-1));
    wait_done(13, 5000);
    if (done_log.size() >= db + 2) begin
      chk("err_done_err", done_log[db].err, 1);
      chk("err_next_clean", done_log[db + 1].err, 0);
    end

    // Reset in the middle of the W phase
    aw_p = 100; w_p = 100; b_p = 100;
    rq1.push_back(rand_req(-1));
    n = 0;
    while (!(!m_idle && w_cnt >= 20) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("rst_reached_beat20", !m_idle && w_cnt >= 20, 1);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_quiet("midrst");
    db = done_log.size();
    rq0.push_back(rand_req(-1));
    wait_done(14, 1000);
    if (done_log.size() > db) begin
      chk("post_rst_ch", done_log[db].ch, 0);
      chk("post_rst_err", done_log[db].err, 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
